// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the seven-segment scan driver:
// active-low segment patterns, decimal-point placement and anode idle value.
package fnd_pkg;

   localparam logic [6:0] SEG_DASH    = 7'h3F;
   localparam logic [6:0] SEG_OFF     = 7'h7F;
   localparam logic [7:0] AN_OFF      = 8'hFF;
   localparam logic [7:0] DP_HHMMSScc = 8'b0101_0100;

   // Active-low gfedcba patterns for BCD 0..9
   localparam logic [6:0] SEG7_DIGITS [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   typedef logic [7:0][3:0] digit_bank_t;

   function automatic logic [7:0] anode_select(input logic [2:0] idx);
      logic [7:0] sel;
      sel = AN_OFF;
      sel[idx] = 1'b0;
      return sel;
   endfunction

endpackage : fnd_pkg

// File: rtl/fnd_scan_driver_bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decode; codes above 9
// render as a dash so corrupt digits stay visible instead of blank.
module bcd_to_seg7
   import fnd_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   // Table lookup with an explicit dash for the six invalid codes
   always_comb begin
      o_seg = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg = SEG7_DIGITS[0];
         4'd1:    o_seg = SEG7_DIGITS[1];
         4'd2:    o_seg = SEG7_DIGITS[2];
         4'd3:    o_seg = SEG7_DIGITS[3];
         4'd4:    o_seg = SEG7_DIGITS[4];
         4'd5:    o_seg = SEG7_DIGITS[5];
         4'd6:    o_seg = SEG7_DIGITS[6];
         4'd7:    o_seg = SEG7_DIGITS[7];
         4'd8:    o_seg = SEG7_DIGITS[8];
         4'd9:    o_seg = SEG7_DIGITS[9];
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule : bcd_to_seg7

// File: rtl/fnd_scan_driver.sv
// Eight-digit common-anode scan driver: frame-atomic digit snapshot, per-slot
// dead time against ghosting, and registered active-low display outputs.
module fnd_scan_driver
   import fnd_pkg::*;
#(
   parameter int unsigned DIV     = 32'd12500,
   parameter int unsigned BLANK   = 32'd16,
   parameter logic [7:0]  DP_MASK = DP_HHMMSScc
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_num7,
   input  logic [3:0] i_num6,
   input  logic [3:0] i_num5,
   input  logic [3:0] i_num4,
   input  logic [3:0] i_num3,
   input  logic [3:0] i_num2,
   input  logic [3:0] i_num1,
   input  logic [3:0] i_num0,
   input  logic [7:0] i_digit_en,
   output logic [7:0] o_an,
   output logic [6:0] o_seg,
   output logic       o_dp,
   output logic       o_frame
);

   localparam int unsigned    CW        = $clog2(DIV);
   localparam logic [CW-1:0]  CNT_LAST  = CW'(DIV - 32'd1);
   localparam logic [CW-1:0]  BLANK_END = CW'(BLANK);
   localparam logic [CW-1:0]  CNT_ONE   = CW'(32'd1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   digit_bank_t   snap_num_q, snap_num_d;
   logic [7:0]    snap_en_q, snap_en_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          frame_q, frame_d;

   logic          slot_end_s;
   logic          frame_end_s;
   logic          lit_s;
   logic [3:0]    cur_num_s;
   logic [6:0]    cur_seg_s;

   // Slot and frame boundary detection
   always_comb begin
      slot_end_s  = (cnt_q == CNT_LAST);
      frame_end_s = slot_end_s && (idx_q == 3'd0);
   end

   // Slot counter and digit index; idx counts down and wraps 0 -> 7
   always_comb begin
      cnt_d = cnt_q + CNT_ONE;
      idx_d = idx_q;
      if (slot_end_s) begin
         cnt_d = '0;
         idx_d = idx_q - 3'd1;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
         idx_d = idx_q;
      end
   end

   // Snapshot capture and frame strobe, only at the end of the digit-0 slot
   always_comb begin
      snap_num_d = snap_num_q;
      snap_en_d  = snap_en_q;
      frame_d    = 1'b0;
      if (frame_end_s) begin
         snap_num_d = {i_num7, i_num6, i_num5, i_num4,
                       i_num3, i_num2, i_num1, i_num0};
         snap_en_d  = i_digit_en;
         frame_d    = 1'b1;
      end else begin
         snap_num_d = snap_num_q;
         snap_en_d  = snap_en_q;
         frame_d    = 1'b0;
      end
   end

   // Current digit selection feeding the single shared decoder
   always_comb begin
      cur_num_s = snap_num_q[idx_q];
      lit_s     = (cnt_q >= BLANK_END) && snap_en_q[idx_q];
   end

   bcd_to_seg7 u_bcd_to_seg7 (
      .i_bcd (cur_num_s),
      .o_seg (cur_seg_s)
   );

   // Output decode: everything dark during dead time or for a masked digit
   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (lit_s) begin
         an_d  = anode_select(idx_q);
         seg_d = cur_seg_s;
         dp_d  = ~DP_MASK[idx_q];
      end else begin
         an_d  = AN_OFF;
         seg_d = SEG_OFF;
         dp_d  = 1'b1;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q      <= '0;
         idx_q      <= 3'd7;
         snap_num_q <= '0;
         snap_en_q  <= 8'hFF;
         an_q       <= AN_OFF;
         seg_q      <= SEG_OFF;
         dp_q       <= 1'b1;
         frame_q    <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         snap_num_q <= snap_num_d;
         snap_en_q  <= snap_en_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         frame_q    <= frame_d;
      end
   end

   assign o_an    = an_q;
   assign o_seg   = seg_q;
   assign o_dp    = dp_q;
   assign o_frame = frame_q;

endmodule : fnd_scan_driver

// File: tb/tb_fnd_scan_driver.sv
// Self-checking bench for fnd_scan_driver with DIV=8, BLANK=2: a time-based
// reference model checked every cycle plus hand-computed literal points.
module tb_fnd_scan_driver;

   localparam logic [7:0] DPM = 8'b0101_0100;

   logic       clk;
   logic       rst;
   logic [3:0] num [8];
   logic [7:0] en;
   logic [7:0] o_an;
   logic [6:0] o_seg;
   logic       o_dp;
   logic       o_frame;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // model state: n = clean edges since the last reset edge
   int         n;
   logic [3:0] m_num [8];
   logic [7:0] m_en;
   logic [7:0] exp_an;
   logic [6:0] exp_seg;
   logic       exp_dp;
   logic       exp_frame;

   fnd_scan_driver #(.DIV(32'd8), .BLANK(32'd2), .DP_MASK(8'b0101_0100)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_num7     (num[7]),
      .i_num6     (num[6]),
      .i_num5     (num[5]),
      .i_num4     (num[4]),
      .i_num3     (num[3]),
      .i_num2     (num[2]),
      .i_num1     (num[1]),
      .i_num0     (num[0]),
      .i_digit_en (en),
      .o_an       (o_an),
      .o_seg      (o_seg),
      .o_dp       (o_dp),
      .o_frame    (o_frame)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [6:0] seg_model(input logic [3:0] v);
      case (v)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   // digit being scanned s cycles after reset: slot s/8, digits run 7 down to 0
   function automatic int digit_of(input int s);
      return 7 - ((s / 8) % 8);
   endfunction

   function automatic bit m_lit(input int s, input logic [7:0] e);
      return ((s % 8) >= 2) && e[digit_of(s)];
   endfunction

   function automatic logic [7:0] an_of(input int d);
      logic [7:0] a;
      a = 8'hFF;
      a[d] = 1'b0;
      return a;
   endfunction

   // reference model: expected registered outputs from elapsed time and snapshot
   always @(posedge clk) begin
      if (rst) begin
         n         <= 0;
         m_num     <= '{default: 4'd0};
         m_en      <= 8'hFF;
         exp_an    <= 8'hFF;
         exp_seg   <= 7'h7F;
         exp_dp    <= 1'b1;
         exp_frame <= 1'b0;
      end else begin
         n         <= n + 1;
         exp_an    <= m_lit(n, m_en) ? an_of(digit_of(n)) : 8'hFF;
         exp_seg   <= m_lit(n, m_en) ? seg_model(m_num[digit_of(n)]) : 7'h7F;
         exp_dp    <= m_lit(n, m_en) ? ~DPM[digit_of(n)] : 1'b1;
         exp_frame <= ((n % 64) == 63);
         if ((n % 64) == 63) begin
            m_num <= num;
            m_en  <= en;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at n=%0d: actual=%h required=%h", name, n, act, req);
      end
   endtask

   // per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_an", {24'd0, o_an}, {24'd0, exp_an});
         chk("model_seg", {25'd0, o_seg}, {25'd0, exp_seg});
         chk("model_dp", {31'd0, o_dp}, {31'd0, exp_dp});
         chk("model_frame", {31'd0, o_frame}, {31'd0, exp_frame});
         chk("one_anode_max", {31'd0, ($countones(~o_an) <= 1)}, 32'd1);
      end
   end

   task automatic wait_n(input int target);
      int budget;
      budget = 1000;
      while (n != target && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (n != target) begin
         checks++;
         errors++;
         $display("FAIL wait_n: actual=%0d required=%0d", n, target);
      end
   endtask

   task automatic lit3(input string name, input logic [7:0] an, input logic [6:0] sg,
                       input logic dp);
      chk({name, "_an"}, {24'd0, o_an}, {24'd0, an});
      chk({name, "_seg"}, {25'd0, o_seg}, {25'd0, sg});
      chk({name, "_dp"}, {31'd0, o_dp}, {31'd0, dp});
   endtask

   logic [7:0] first_an [12];

   initial begin
      rst = 1'b1;
      num = '{default: 4'd0};
      en  = 8'hFF;
      first_an = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'h7F,
                   8'h7F, 8'h7F, 8'h7F, 8'hFF, 8'hFF, 8'hBF};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      rst = 1'b0;
      lit3("reset", 8'hFF, 7'h7F, 1'b1);
      chk("reset_frame", {31'd0, o_frame}, 32'd0);

      // first frame: dead time, digit 7 zeros, dead time, digit 6 with dp
      for (int k = 0; k < 12; k++) begin
         wait_n(k);
         chk("first_an", {24'd0, o_an}, {24'd0, first_an[k]});
      end
      lit3("first_d6", 8'hBF, 7'h40, 1'b0);

      // snapshot isolation: change digit 0 during the idx=3 slot
      wait_n(36);
      num[0] = 4'd5;
      wait_n(60);
      lit3("iso_old", 8'hFE, 7'h40, 1'b1);
      wait_n(63);
      chk("iso_frame_pre", {31'd0, o_frame}, 32'd0);
      wait_n(64);
      chk("iso_frame", {31'd0, o_frame}, 32'd1);
      wait_n(65);
      chk("iso_frame_post", {31'd0, o_frame}, 32'd0);

      // blanking of digit 4 plus invalid BCD on digit 2, latched next frame
      wait_n(70);
      en     = 8'b1110_1111;
      num[2] = 4'hB;
      wait_n(124);
      lit3("iso_new", 8'hFE, 7'h12, 1'b1);
      for (int k = 153; k <= 160; k++) begin
         wait_n(k);
         chk("blank_d4", {24'd0, o_an}, 32'h0000_00FF);
      end
      wait_n(163);
      lit3("d3_unaffected", 8'hF7, 7'h40, 1'b1);
      wait_n(171);
      lit3("invalid_d2", 8'hFB, 7'h3F, 1'b0);

      // full scan of 23:59:59.99
      wait_n(175);
      num = '{4'd9, 4'd9, 4'd9, 4'd5, 4'd9, 4'd5, 4'd3, 4'd2};
      en  = 8'hFF;
      wait_n(195);
      lit3("full_d7", 8'h7F, 7'h24, 1'b1);
      wait_n(203);
      lit3("full_d6", 8'hBF, 7'h30, 1'b0);
      wait_n(211);
      lit3("full_d5", 8'hDF, 7'h12, 1'b1);
      wait_n(251);
      lit3("full_d0", 8'hFE, 7'h10, 1'b1);
      wait_n(256);
      chk("full_frame", {31'd0, o_frame}, 32'd1);

      // reset mid-frame at idx=4, cnt=5
      wait_n(285);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      lit3("midrst", 8'hFF, 7'h7F, 1'b1);
      chk("midrst_frame", {31'd0, o_frame}, 32'd0);
      chk("midrst_n", n, 32'd0);
      wait_n(3);
      lit3("restart_d7", 8'h7F, 7'h40, 1'b1);
      wait_n(80);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fnd_scan_driver
